// File: rtl/cam_match_iter.sv
// Iterates the set bits of a 64-bit CAM hit vector, lowest index first, over a valid/ready port.
// Optional CAM_MATCH_ITER_CNT_EN adds a registered popcount (match_cnt) of each accepted vector.
module cam_match_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        match_valid,
  output logic        match_ready,
  input  logic [63:0] match_vec,
  input  logic        flush,
  output logic        idx_valid,
  input  logic        idx_ready,
  output logic [5:0]  idx,
  output logic        idx_last,
  output logic        miss,
  output logic        busy
`ifdef CAM_MATCH_ITER_CNT_EN
  ,
  output logic [6:0]  match_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t      state_r, state_nxt;
  logic [63:0] pending_r, pending_nxt;
  logic        miss_r, miss_nxt;
  logic        accept_s, transfer_s, vec_zero_s;
  logic [5:0]  idx_s;
  logic        idx_last_s;

  function automatic logic [5:0] lsb_index(input logic [63:0] v);
    lsb_index = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) begin
        lsb_index = i[5:0];
      end else begin
        lsb_index = lsb_index;
      end
    end
  endfunction

  function automatic logic single_bit(input logic [63:0] v);
    single_bit = (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

  assign accept_s    = match_valid & match_ready;
  assign transfer_s  = idx_valid & idx_ready;
  assign vec_zero_s  = (match_vec == 64'd0);
  // Pending is zero whenever idle, so idx/idx_last naturally read 0 there.
  assign idx_s       = lsb_index(pending_r);
  assign idx_last_s  = single_bit(pending_r);

  assign match_ready = (state_r == IDLE);
  assign idx_valid   = (state_r == ITER);
  assign busy        = (state_r == ITER);
  assign idx         = idx_s;
  assign idx_last    = idx_last_s;
  assign miss        = miss_r;

  // State, pending vector and miss pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= 64'd0;
      miss_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      pending_r <= pending_nxt;
      miss_r    <= miss_nxt;
    end
  end

  // Next-state logic; flush outranks a coincident transfer.
  always_comb begin
    state_nxt   = state_r;
    pending_nxt = pending_r;
    miss_nxt    = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          miss_nxt = vec_zero_s;
          if (vec_zero_s) begin
            pending_nxt = 64'd0;
            state_nxt   = IDLE;
          end else begin
            pending_nxt = match_vec;
            state_nxt   = ITER;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ITER: begin
        if (flush) begin
          pending_nxt = 64'd0;
          state_nxt   = IDLE;
        end else if (transfer_s) begin
          pending_nxt = pending_r & ~(64'd1 << idx_s);
          if (idx_last_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = ITER;
          end
        end else begin
          state_nxt = ITER;
        end
      end
      default: begin
        pending_nxt = 64'd0;
        state_nxt   = IDLE;
      end
    endcase
  end

`ifdef CAM_MATCH_ITER_CNT_EN
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    popcount64 = 7'd0;
    for (int i = 0; i < 64; i++) begin
      popcount64 = popcount64 + {6'd0, v[i]};
    end
  endfunction

  logic [6:0] match_cnt_r;

  // Hit count of the most recently accepted vector, zero vectors included.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt_r <= 7'd0;
    end else if (accept_s) begin
      match_cnt_r <= popcount64(match_vec);
    end else begin
      match_cnt_r <= match_cnt_r;
    end
  end

  assign match_cnt = match_cnt_r;
`endif

endmodule
